// File: rtl/mem_stage.sv
// MEM stage of the five-stage LoongArch pipeline: latches the EXE bus, waits for the
// data-SRAM response of loads/stores, extends load data and hands the result to WB.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 184,
    parameter int MS_TO_WS_BUS_WD = 172,
    parameter int MS_FORWARD_WD   = 40
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FORWARD_WD-1:0]   ms_forward,
    output logic                       ms_ex,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       excp_flush,
    input  logic                       ertn_flush
);

    logic                       ms_valid_q;
    logic                       ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q;
    logic [ES_TO_MS_BUS_WD-1:0] bus_d;
    logic                       buf_valid_q;
    logic                       buf_valid_d;
    logic [31:0]                buf_data_q;
    logic [31:0]                buf_data_d;
    logic                       cancel_q;
    logic                       cancel_d;

    logic [31:0] pc_s;
    logic [31:0] alu_result_s;
    logic [4:0]  dest_s;
    logic        gr_we_s;
    logic        res_from_mem_s;
    logic        res_from_csr_s;
    logic        st_h_s;
    logic        st_b_s;
    logic        st_w_s;
    logic        ld_hu_s;
    logic        ld_h_s;
    logic        ld_bu_s;
    logic        ld_b_s;
    logic        ld_w_s;
    logic        mem_we_s;
    logic [1:0]  addr_s;
    logic [3:0]  mul_div_op_s;
    logic        mul_div_sign_s;
    logic        excp_s;
    logic [15:0] excp_num_s;
    logic        csr_we_s;
    logic [13:0] csr_num_s;
    logic [31:0] csr_wmask_s;
    logic [31:0] csr_wdata_s;

    logic        flush_s;
    logic        mem_access_s;
    logic        wait_data_s;
    logic        resp_s;
    logic        ms_ready_go_s;
    logic        leave_s;
    logic [31:0] mem_rdata_s;
    logic [31:0] load_value_s;
    logic [31:0] final_result_s;
    logic        load_pending_s;
    logic        unused_s;

    // Byte/half lane select and extension of a returned load word.
    function automatic logic [31:0] load_extend(
        input logic [31:0] rdata,
        input logic [1:0]  addr,
        input logic        ld_b,
        input logic        ld_bu,
        input logic        ld_h,
        input logic        ld_hu
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        case (addr)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            2'd3:    byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];
        if (ld_b) begin
            load_extend = {{24{byte_v[7]}}, byte_v};
        end else if (ld_bu) begin
            load_extend = {24'd0, byte_v};
        end else if (ld_h) begin
            load_extend = {{16{half_v[15]}}, half_v};
        end else if (ld_hu) begin
            load_extend = {16'd0, half_v};
        end else begin
            load_extend = rdata;
        end
    endfunction

    assign pc_s           = bus_q[31:0];
    assign alu_result_s   = bus_q[63:32];
    assign dest_s         = bus_q[68:64];
    assign gr_we_s        = bus_q[69];
    assign res_from_mem_s = bus_q[70];
    assign res_from_csr_s = bus_q[71];
    assign st_h_s         = bus_q[72];
    assign st_b_s         = bus_q[73];
    assign st_w_s         = bus_q[74];
    assign ld_hu_s        = bus_q[75];
    assign ld_h_s         = bus_q[76];
    assign ld_bu_s        = bus_q[77];
    assign ld_b_s         = bus_q[78];
    assign ld_w_s         = bus_q[79];
    assign mem_we_s       = bus_q[80];
    assign addr_s         = bus_q[82:81];
    assign mul_div_op_s   = bus_q[86:83];
    assign mul_div_sign_s = bus_q[87];
    assign excp_s         = bus_q[88];
    assign excp_num_s     = bus_q[104:89];
    assign csr_we_s       = bus_q[105];
    assign csr_num_s      = bus_q[119:106];
    assign csr_wmask_s    = bus_q[151:120];
    assign csr_wdata_s    = bus_q[183:152];

    // Store size and word-load flags are consumed by EXE and the SRAM, not here.
    assign unused_s = ^{st_h_s, st_b_s, st_w_s, ld_w_s};

    assign flush_s       = excp_flush | ertn_flush;
    assign mem_access_s  = res_from_mem_s | mem_we_s;
    assign wait_data_s   = ms_valid_q & mem_access_s & ~excp_s;
    assign resp_s        = data_sram_data_ok & ~cancel_q;
    assign ms_ready_go_s = ~wait_data_s | buf_valid_q | resp_s;
    assign ms_allowin    = ~ms_valid_q | (ms_ready_go_s & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go_s;
    assign leave_s       = ms_to_ws_valid & ws_allowin;

    assign mem_rdata_s    = buf_valid_q ? buf_data_q : data_sram_rdata;
    assign load_value_s   = load_extend(mem_rdata_s, addr_s, ld_b_s, ld_bu_s, ld_h_s, ld_hu_s);
    assign final_result_s = res_from_mem_s ? load_value_s : alu_result_s;
    assign load_pending_s = ms_valid_q & res_from_mem_s & ~ms_ready_go_s;

    assign ms_ex = ms_valid_q & excp_s;

    assign ms_to_ws_bus = {mul_div_sign_s, mul_div_op_s, csr_wdata_s, csr_wmask_s,
                           csr_num_s, csr_we_s, excp_num_s, excp_s, res_from_csr_s,
                           gr_we_s, dest_s, final_result_s, pc_s};

    assign ms_forward = {load_pending_s, final_result_s, dest_s, gr_we_s, ms_valid_q};

    // Next-state for the valid bit and the latched EXE bus.
    always_comb begin
        ms_valid_d = ms_valid_q;
        bus_d      = bus_q;
        if (flush_s) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end else begin
            ms_valid_d = ms_valid_q;
        end
        if (es_to_ms_valid & ms_allowin) begin
            bus_d = es_to_ms_bus;
        end else begin
            bus_d = bus_q;
        end
    end

    // Next-state for the read-data buffer and the orphan-response cancel flag.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        cancel_d    = cancel_q;
        if (flush_s | leave_s) begin
            buf_valid_d = 1'b0;
        end else if (resp_s & wait_data_s & ~buf_valid_q & ~ws_allowin) begin
            buf_valid_d = 1'b1;
            buf_data_d  = data_sram_rdata;
        end else begin
            buf_valid_d = buf_valid_q;
        end
        // A response arriving with the flush belongs to the flushed instruction.
        if (cancel_q) begin
            cancel_d = flush_s | ~data_sram_data_ok;
        end else begin
            cancel_d = flush_s & wait_data_s & ~buf_valid_q & ~data_sram_data_ok;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            bus_q       <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= 32'd0;
            cancel_q    <= 1'b0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            bus_q       <= bus_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            cancel_q    <= cancel_d;
        end
    end

    // A response with nothing waiting for it means core and SRAM lost step.
    assert property (@(posedge clk) disable iff (!resetn)
        data_sram_data_ok |-> (ms_valid_q | cancel_q));

endmodule
